// File: rtl/barrel_pipe.sv
// ============================================================================
//  Module      : barrel_pipe
//  Description : Pipelined barrel shifter/rotator, one mux layer per shamt bit,
//                grouped into registered stages with valid/ready on both ends.
//                Optional macro BARREL_PIPE_ROTATE_EN enables ROL/ROR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_LAYERS = 5,
    parameter int TAG_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [$clog2(WIDTH)-1:0]  in_shamt,
    input  logic [2:0]                in_op,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      busy
);

    localparam int c_shw = $clog2(WIDTH);
    localparam int c_ns  = (c_shw + PIPE_LAYERS - 1) / PIPE_LAYERS;

    localparam logic [2:0] c_op_sll = 3'b000;
    localparam logic [2:0] c_op_srl = 3'b001;
    localparam logic [2:0] c_op_sra = 3'b011;
    localparam logic [2:0] c_op_rol = 3'b100;
    localparam logic [2:0] c_op_ror = 3'b101;

    // One mux layer: shift/rotate by a fixed power-of-two amount.
    function automatic logic [WIDTH-1:0] f_layer(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             fill,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            c_op_sll: r = d << amt;
            c_op_srl: r = d >> amt;
            c_op_sra: r = fill ? ~((~d) >> amt) : (d >> amt);
            c_op_rol: begin
`ifdef BARREL_PIPE_ROTATE_EN
                r = (d << amt) | (d >> (WIDTH - amt));
`else
                r = d << amt;
`endif
            end
            c_op_ror: begin
`ifdef BARREL_PIPE_ROTATE_EN
                r = (d >> amt) | (d << (WIDTH - amt));
`else
                r = d >> amt;
`endif
            end
            default:  r = d;
        endcase
        return r;
    endfunction

    logic [c_ns:0]   w_rdy;
    logic [c_ns-1:0] w_valid;

    assign w_rdy[c_ns] = out_ready;

    generate
        for (genvar s = 0; s < c_ns; s++) begin : g_stage
            localparam int c_lo  = s * PIPE_LAYERS;
            localparam int c_hi  = (c_lo + PIPE_LAYERS < c_shw) ? c_lo + PIPE_LAYERS : c_shw;
            localparam int c_nl  = c_hi - c_lo;
            localparam int c_win = c_shw - c_lo;

            logic               w_vin;
            logic               w_fill;
            logic [WIDTH-1:0]   w_din;
            logic [c_win-1:0]   w_shamt;
            logic [2:0]         w_op;
            logic [TAG_W-1:0]   w_tag;
            logic [WIDTH-1:0]   w_lyr [c_nl+1];
            logic               w_load;

            logic               r_valid;
            logic [WIDTH-1:0]   r_data;
            logic [TAG_W-1:0]   r_tag;

            if (s == 0) begin : g_src_port
                assign w_vin   = in_valid;
                assign w_din   = in_data;
                assign w_shamt = in_shamt;
                assign w_op    = in_op;
                assign w_tag   = in_tag;
                // Sign for SRA is frozen at acceptance and carried down the pipe.
                assign w_fill  = in_data[WIDTH-1];
            end else begin : g_src_stage
                assign w_vin   = g_stage[s-1].r_valid;
                assign w_din   = g_stage[s-1].r_data;
                assign w_shamt = g_stage[s-1].g_fwd.r_shamt;
                assign w_op    = g_stage[s-1].g_fwd.r_op;
                assign w_tag   = g_stage[s-1].r_tag;
                assign w_fill  = g_stage[s-1].g_fwd.r_fill;
            end

            assign w_lyr[0] = w_din;
            for (genvar k = 0; k < c_nl; k++) begin : g_layer
                assign w_lyr[k+1] = w_shamt[k]
                                  ? f_layer(w_lyr[k], w_op, w_fill, 1 << (c_lo + k))
                                  : w_lyr[k];
            end

            assign w_rdy[s]   = !r_valid || w_rdy[s+1];
            assign w_valid[s] = r_valid;
            assign w_load     = w_rdy[s] && w_vin;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_tag   <= '0;
                end else if (w_rdy[s]) begin
                    r_valid <= w_vin;
                    if (w_vin) begin
                        r_data <= w_lyr[c_nl];
                        r_tag  <= w_tag;
                    end
                end
            end

            // Only the shamt bits still to be consumed travel to the next stage.
            if (s < c_ns - 1) begin : g_fwd
                localparam int c_wout = c_shw - c_hi;
                logic [c_wout-1:0] r_shamt;
                logic [2:0]        r_op;
                logic              r_fill;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_shamt <= '0;
                        r_op    <= '0;
                        r_fill  <= 1'b0;
                    end else if (w_load) begin
                        r_shamt <= w_shamt[c_win-1:c_nl];
                        r_op    <= w_op;
                        r_fill  <= w_fill;
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = w_rdy[0];
    assign out_valid = g_stage[c_ns-1].r_valid;
    assign out_data  = g_stage[c_ns-1].r_data;
    assign out_tag   = g_stage[c_ns-1].r_tag;
    assign busy      = |w_valid;

endmodule

`default_nettype wire

// File: tb/tb_barrel_pipe.sv
// ============================================================================
//  Module      : tb_barrel_pipe
//  Description : Directed self-checking bench for barrel_pipe; instance A uses
//                a single stage, instance B one layer per stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_shamt;
    logic [2:0]  a_in_op;
    logic [3:0]  a_in_tag, a_out_tag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [31:0] b_in_data, b_out_data;
    logic [4:0]  b_in_shamt;
    logic [2:0]  b_in_op;
    logic [3:0]  b_in_tag, b_out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] qa_data[$];
    int          qa_tag[$];
    int          qa_cyc[$];
    logic [31:0] qb_data[$];
    int          qb_tag[$];
    int          qb_cyc[$];

    barrel_pipe #(.WIDTH(32), .PIPE_LAYERS(5), .TAG_W(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_shamt(a_in_shamt), .in_op(a_in_op), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .busy(a_busy)
    );

    barrel_pipe #(.WIDTH(32), .PIPE_LAYERS(1), .TAG_W(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result monitors: a transfer seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            qa_data.push_back(a_out_data);
            qa_tag.push_back(int'(a_out_tag));
            qa_cyc.push_back(cyc);
        end
        if (!rst && b_out_valid && b_out_ready) begin
            qb_data.push_back(b_out_data);
            qb_tag.push_back(int'(b_out_tag));
            qb_cyc.push_back(cyc);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic op_a(input string nm, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] sh, input logic [3:0] tg, input logic [31:0] exp);
        int acc;
        int n;
        qa_data.delete(); qa_tag.delete(); qa_cyc.delete();
        @(posedge clk); #1;
        a_in_op = op; a_in_data = d; a_in_shamt = sh; a_in_tag = tg; a_in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_in_ready && n < 50);
        acc = cyc;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n = 0;
        while (qa_data.size() == 0 && n < 50) begin @(negedge clk); n++; end
        if (qa_data.size() == 0) begin
            check_value({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_value({nm, "_data"}, qa_data[0], exp);
            check_value({nm, "_tag"}, 32'(qa_tag[0]), {28'd0, tg});
            check_value({nm, "_latency"}, 32'(qa_cyc[0] - acc), 32'd1);
        end
    endtask

    task automatic send_b(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                          input logic [3:0] tg, output int acc);
        int n;
        b_in_op = op; b_in_data = d; b_in_shamt = sh; b_in_tag = tg; b_in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_in_ready && n < 50);
        acc = cyc;
        if (!b_in_ready) check_value("send_b_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    logic [31:0] exp_bp [7] = '{32'h8000_0000, 32'hF800_0000, 32'hFF80_0000, 32'hFFF8_0000,
                                32'hFFFF_8000, 32'hFFFF_F800, 32'hFFFF_FF80};

    initial begin
        int acc;
        int acc0;
        int n;
        int bad;
        logic [31:0] hold;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_op = '0; a_in_tag = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_in_tag = '0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        #12;
        check_value("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check_value("rst_a_out_data", a_out_data, 32'd0);
        check_value("rst_a_out_tag", {28'd0, a_out_tag}, 32'd0);
        check_value("rst_a_busy", 32'(a_busy), 32'd0);
        check_value("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        check_value("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        check_value("rst_b_busy", 32'(b_busy), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Single-stage arithmetic
        op_a("sra31",   3'b011, 32'h8000_0000, 5'd31, 4'd1, 32'hFFFF_FFFF);
        op_a("srl31",   3'b001, 32'h8000_0000, 5'd31, 4'd2, 32'h0000_0001);
`ifdef BARREL_PIPE_ROTATE_EN
        op_a("rol1",    3'b100, 32'h8000_0001, 5'd1,  4'd3, 32'h0000_0003);
        op_a("ror4",    3'b101, 32'h0000_0001, 5'd4,  4'd4, 32'h1000_0000);
`else
        op_a("rol1",    3'b100, 32'h8000_0001, 5'd1,  4'd3, 32'h0000_0002);
        op_a("ror4",    3'b101, 32'h0000_0001, 5'd4,  4'd4, 32'h0000_0000);
`endif
        op_a("rsv110",  3'b110, 32'hDEAD_BEEF, 5'd7,  4'd5, 32'hDEAD_BEEF);
        op_a("sra0",    3'b011, 32'h8000_0000, 5'd0,  4'd6, 32'h8000_0000);
        op_a("sll31",   3'b000, 32'h0000_0001, 5'd31, 4'd7, 32'h8000_0000);
        op_a("sra_pos", 3'b011, 32'h7000_0000, 5'd4,  4'd8, 32'h0700_0000);

        // Five-stage streaming, out_ready held high
        @(posedge clk); #1;
        qb_data.delete(); qb_tag.delete(); qb_cyc.delete();
        acc0 = 0;
        for (int i = 0; i < 8; i++) begin
            send_b(3'b000, 32'd1, 5'(i), 4'(i), acc);
            if (i == 0) acc0 = acc;
        end
        n = 0;
        while (qb_data.size() < 8 && n < 50) begin @(negedge clk); n++; end
        check_value("stream_count", 32'(qb_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < qb_data.size(); i++) begin
            check_value($sformatf("stream_data%0d", i), qb_data[i], 32'd1 << i);
            check_value($sformatf("stream_tag%0d", i), 32'(qb_tag[i]), 32'(i));
            check_value($sformatf("stream_cyc%0d", i), 32'(qb_cyc[i] - acc0), 32'(5 + i));
        end

        // Backpressure: fill with SRA ops, stall 10 cycles, then drain
        @(posedge clk); #1;
        qb_data.delete(); qb_tag.delete(); qb_cyc.delete();
        b_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_b(3'b011, 32'h8000_0000, 5'(4 * i), 4'(i), acc);
        fork
            begin
                send_b(3'b011, 32'h8000_0000, 5'd20, 4'd5, acc);
                send_b(3'b011, 32'h8000_0000, 5'd24, 4'd6, acc);
            end
            begin
                @(negedge clk);
                check_value("bp_in_ready", 32'(b_in_ready), 32'd0);
                check_value("bp_out_valid", 32'(b_out_valid), 32'd1);
                check_value("bp_out_data", b_out_data, exp_bp[0]);
                hold = b_out_data;
                bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (b_out_data !== hold || b_out_tag !== 4'd0 || !b_out_valid || b_in_ready) bad++;
                end
                check_value("bp_stable", 32'(bad), 32'd0);
                @(posedge clk); #1;
                b_out_ready = 1'b1;
            end
        join
        n = 0;
        while (qb_data.size() < 7 && n < 60) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        check_value("bp_count", 32'(qb_data.size()), 32'd7);
        for (int i = 0; i < 7 && i < qb_data.size(); i++) begin
            check_value($sformatf("bp_data%0d", i), qb_data[i], exp_bp[i]);
            check_value($sformatf("bp_tag%0d", i), 32'(qb_tag[i]), 32'(i));
        end

        // Reset with three ops in flight
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send_b(3'b000, 32'd1, 5'(i), 4'(9 + i), acc);
        #2;
        check_value("rst_busy_before", 32'(b_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_value("rst_mid_out_valid", 32'(b_out_valid), 32'd0);
        check_value("rst_mid_busy", 32'(b_busy), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        qb_data.delete(); qb_tag.delete(); qb_cyc.delete();
        repeat (12) @(negedge clk);
        check_value("rst_no_stale", 32'(qb_data.size()), 32'd0);
        check_value("rst_busy_after", 32'(b_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
